sched_operand_frontend: RTL and testbench



---
 rtl/sched_operand_frontend_if.sv | 31 +++
 rtl/sched_operand_frontend.sv | 126 ++++++++++++
 tb/tb_sched_operand_frontend.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sched_operand_frontend_if.sv
// Stream and controller-side signal bundle for the scheduled-datapath operand frontend.
// The slave modport is the frontend itself; master is whatever drives it (sequencer or bench).
interface sched_operand_frontend_if #(
  parameter int DATA_W = 16,
  parameter int NUM_IN = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [NUM_IN*DATA_W-1:0] opnd_bus;
  logic                     op_ready;
  logic                     start;
  logic                     done;
  logic [DATA_W-1:0]        result;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_err;
  logic                     busy;
  logic [7:0]               job_cnt;

  modport slave (
    input  in_valid, in_data, op_ready, done, result, out_ready,
    output in_ready, opnd_bus, start, out_valid, out_data, out_err, busy, job_cnt
  );

  modport master (
    output in_valid, in_data, op_ready, done, result, out_ready,
    input  in_ready, opnd_bus, start, out_valid, out_data, out_err, busy, job_cnt
  );
endinterface

// File: rtl/sched_operand_frontend.sv
// Operand collector / start issuer / result holder wrapped around a scheduled datapath,
// with a RUN watchdog and a wrapping completed-job counter.
//
// state | meaning
// LOAD  | accepting operand words into opnd_bus slots
// ISSUE | operands complete, start pulses as soon as op_ready is seen
// RUN   | waiting for done, watchdog counting
// OUT   | result (or abort marker) held until out_ready
module sched_operand_frontend #(
  parameter int DATA_W  = 16,
  parameter int NUM_IN  = 3,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  sched_operand_frontend_if.slave bus
);

  localparam int WCNT_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(NUM_IN - 1);
  // Abort on the cycle whose increment would bring the counter to TIMEOUT-1,
  // so the abort result appears exactly TIMEOUT cycles after start.
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {LOAD, ISSUE, RUN, OUT} state_e;

  state_e                   state_q, state_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [TCNT_W-1:0]        tcnt_q, tcnt_d;
  logic [NUM_IN*DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_err_q, out_err_d;
  logic [7:0]               job_cnt_q, job_cnt_d;

  logic in_fire, last_word, timed_out;

  assign in_fire   = (state_q == LOAD) && bus.in_valid;
  assign last_word = (wcnt_q == W_LAST);
  assign timed_out = (tcnt_q == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && last_word)       state_d = ISSUE;
      ISSUE:   if (bus.op_ready)               state_d = RUN;
      RUN:     if (bus.done || timed_out)      state_d = OUT;
      OUT:     if (bus.out_ready)              state_d = LOAD;
      default:                                 state_d = LOAD;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == LOAD);
    bus.start     = (state_q == ISSUE) && bus.op_ready;
    bus.out_valid = (state_q == OUT);
    bus.busy      = (state_q != LOAD);
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    tcnt_d     = tcnt_q;
    opnd_d     = opnd_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    job_cnt_d  = job_cnt_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          for (int i = 0; i < NUM_IN; i++) begin
            if (wcnt_q == WCNT_W'(i)) opnd_d[i*DATA_W +: DATA_W] = bus.in_data;
          end
          wcnt_d = last_word ? '0 : wcnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (bus.op_ready) tcnt_d = '0;
      end
      RUN: begin
        // done takes priority over a coincident watchdog expiry
        if (bus.done) begin
          out_data_d = bus.result;
          out_err_d  = 1'b0;
        end else if (timed_out) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) job_cnt_d = job_cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      opnd_q     <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      job_cnt_q  <= 8'd0;
    end else begin
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      opnd_q     <= opnd_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      job_cnt_q  <= job_cnt_d;
    end
  end

  assign bus.opnd_bus = opnd_q;
  assign bus.out_data = out_data_q;
  assign bus.out_err  = out_err_q;
  assign bus.job_cnt  = job_cnt_q;

endmodule

// File: tb/tb_sched_operand_frontend.sv
// Directed bench for sched_operand_frontend: expected results go into a scoreboard queue
// when done (or a timeout) is provoked and are popped when the result is handed off.
module tb_sched_operand_frontend;
  localparam int DATA_W  = 16;
  localparam int NUM_IN  = 3;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sched_operand_frontend_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN)) bif();

  sched_operand_frontend #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_jobs = 0;
  logic [DATA_W:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic err, input logic [DATA_W-1:0] data);
    sb_q.push_back({err, data});
  endtask

  // Streams three words (optionally with idle gaps) and returns #1 into the ISSUE cycle.
  task automatic load3(input logic [DATA_W-1:0] a, b, c, input bit gap);
    logic [DATA_W-1:0] w[3];
    w[0] = a; w[1] = b; w[2] = c;
    for (int i = 0; i < 3; i++) begin
      if (gap && i > 0) begin
        @(negedge clk); bif.in_valid = 1'b0; bif.in_data = 16'hFFFF;
      end
      @(negedge clk); bif.in_valid = 1'b1; bif.in_data = w[i];
    end
    @(negedge clk); bif.in_valid = 1'b0; bif.in_data = 16'hFFFF;
    #1;
  endtask

  // Called #1 into an OUT cycle: compares against the scoreboard and completes the handshake.
  task automatic finish_out(input string tag);
    logic [DATA_W:0] e;
    chk({tag, "_out_valid"}, 64'(bif.out_valid), 64'd1);
    chk({tag, "_sb_entry"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_out_data"}, 64'(bif.out_data), 64'(e[DATA_W-1:0]));
      chk({tag, "_out_err"}, 64'(bif.out_err), 64'(e[DATA_W]));
    end
    bif.out_ready = 1'b1;
    @(negedge clk); bif.out_ready = 1'b0;
    #1;
    exp_jobs = (exp_jobs + 1) % 256;
    chk({tag, "_job_cnt"}, 64'(bif.job_cnt), 64'(exp_jobs));
    chk({tag, "_in_ready_after"}, 64'(bif.in_ready), 64'd1);
    chk({tag, "_out_valid_after"}, 64'(bif.out_valid), 64'd0);
  endtask

  // Full job with op_ready=1: done arrives d cycles after the start cycle.
  task automatic run_job(input logic [DATA_W-1:0] a, b, c, res, input int d, input string tag);
    load3(a, b, c, 1'b0);
    chk({tag, "_start"}, 64'(bif.start), 64'd1);
    chk({tag, "_opnd"}, 64'(bif.opnd_bus), 64'({c, b, a}));
    for (int i = 1; i <= d; i++) begin
      @(negedge clk);
      if (i == d) begin
        bif.done = 1'b1; bif.result = res; push(1'b0, res);
      end
    end
    @(negedge clk); bif.done = 1'b0;
    #1;
    finish_out(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c;
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.in_data = '0; bif.op_ready = 1'b1;
    bif.done = 1'b0; bif.result = '0; bif.out_ready = 1'b0;

    // reset values
    @(negedge clk); #1;
    chk("rst_in_ready", 64'(bif.in_ready), 64'd1);
    chk("rst_start", 64'(bif.start), 64'd0);
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_busy", 64'(bif.busy), 64'd0);
    chk("rst_job_cnt", 64'(bif.job_cnt), 64'd0);
    chk("rst_opnd", 64'(bif.opnd_bus), 64'd0);
    chk("rst_out_data", 64'(bif.out_data), 64'd0);
    chk("rst_out_err", 64'(bif.out_err), 64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: basic job, start one cycle wide, done 4 cycles after start
    load3(16'd5, 16'd7, 16'd9, 1'b0);
    chk("t1_start", 64'(bif.start), 64'd1);
    chk("t1_in_ready", 64'(bif.in_ready), 64'd0);
    chk("t1_opnd", 64'(bif.opnd_bus), 64'({16'd9, 16'd7, 16'd5}));
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) begin
        bif.done = 1'b1; bif.result = 16'h0030; push(1'b0, 16'h0030);
      end
      #1;
      chk("t1_start_low", 64'(bif.start), 64'd0);
      chk("t1_busy_run", 64'(bif.busy), 64'd1);
    end
    @(negedge clk); bif.done = 1'b0;
    #1;
    finish_out("t1");

    // 2: gapped input, then result held under backpressure
    load3(16'd1, 16'd2, 16'd3, 1'b1);
    chk("t2_opnd", 64'(bif.opnd_bus), 64'({16'd3, 16'd2, 16'd1}));
    chk("t2_start", 64'(bif.start), 64'd1);
    @(negedge clk); bif.done = 1'b1; bif.result = 16'h1234; push(1'b0, 16'h1234);
    @(negedge clk); bif.done = 1'b0; bif.in_valid = 1'b1; bif.in_data = 16'hEEEE;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_valid", 64'(bif.out_valid), 64'd1);
      chk("t2_hold_data", 64'(bif.out_data), 64'h1234);
      chk("t2_hold_in_ready", 64'(bif.in_ready), 64'd0);
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    #1;
    chk("t2_opnd_stable", 64'(bif.opnd_bus), 64'({16'd3, 16'd2, 16'd1}));
    finish_out("t2");

    // 3: op_ready held low keeps the job in ISSUE
    bif.op_ready = 1'b0;
    load3(16'h000A, 16'h000B, 16'h000C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t3_start_low", 64'(bif.start), 64'd0);
      chk("t3_busy", 64'(bif.busy), 64'd1);
      chk("t3_in_ready", 64'(bif.in_ready), 64'd0);
      @(negedge clk); #1;
    end
    bif.op_ready = 1'b1;
    #1;
    chk("t3_start", 64'(bif.start), 64'd1);
    @(negedge clk); #1;
    chk("t3_start_once", 64'(bif.start), 64'd0);
    bif.done = 1'b1; bif.result = 16'hBEEF; push(1'b0, 16'hBEEF);
    @(negedge clk); bif.done = 1'b0;
    #1;
    finish_out("t3");

    // 4a: no done -> abort result TIMEOUT cycles after start
    load3(16'h0100, 16'h0200, 16'h0300, 1'b0);
    chk("t4_start", 64'(bif.start), 64'd1);
    c = 0;
    while (!bif.out_valid && c < TIMEOUT + 10) begin
      @(negedge clk); #1;
      c++;
    end
    chk("t4_timeout_latency", 64'(c), 64'(TIMEOUT));
    push(1'b1, 16'h0000);
    finish_out("t4_abort");

    // 4b: done on the expiry cycle wins
    load3(16'h0101, 16'h0202, 16'h0303, 1'b0);
    chk("t4b_start", 64'(bif.start), 64'd1);
    for (int i = 1; i <= TIMEOUT - 1; i++) begin
      @(negedge clk);
      if (i == TIMEOUT - 1) begin
        bif.done = 1'b1; bif.result = 16'h5A5A; push(1'b0, 16'h5A5A);
        #1;
        chk("t4b_not_early", 64'(bif.out_valid), 64'd0);
      end
    end
    @(negedge clk); bif.done = 1'b0;
    #1;
    finish_out("t4b_coincide");

    // 5: done in LOAD and in OUT is ignored
    @(negedge clk); bif.done = 1'b1; bif.result = 16'hDEAD;
    @(negedge clk); bif.done = 1'b0;
    #1;
    chk("t5_load_busy", 64'(bif.busy), 64'd0);
    chk("t5_load_in_ready", 64'(bif.in_ready), 64'd1);
    chk("t5_load_out_data", 64'(bif.out_data), 64'h5A5A);
    chk("t5_load_out_valid", 64'(bif.out_valid), 64'd0);
    load3(16'h0011, 16'h0022, 16'h0033, 1'b0);
    chk("t5_start", 64'(bif.start), 64'd1);
    @(negedge clk); bif.done = 1'b1; bif.result = 16'h0077; push(1'b0, 16'h0077);
    @(negedge clk); bif.done = 1'b1; bif.result = 16'h9999;
    @(negedge clk); bif.done = 1'b0;
    #1;
    chk("t5_out_data", 64'(bif.out_data), 64'h0077);
    chk("t5_out_err", 64'(bif.out_err), 64'd0);
    finish_out("t5");

    // 6: reset during RUN, stray done afterwards
    load3(16'h0AAA, 16'h0BBB, 16'h0CCC, 1'b0);
    chk("t6_start", 64'(bif.start), 64'd1);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; bif.done = 1'b1; bif.result = 16'hABCD;
    @(negedge clk); bif.done = 1'b0;
    #1;
    exp_jobs = 0;
    chk("t6_out_valid", 64'(bif.out_valid), 64'd0);
    chk("t6_job_cnt", 64'(bif.job_cnt), 64'd0);
    chk("t6_opnd", 64'(bif.opnd_bus), 64'd0);
    chk("t6_in_ready", 64'(bif.in_ready), 64'd1);
    chk("t6_out_data", 64'(bif.out_data), 64'd0);
    @(negedge clk); #1;
    chk("t6_out_valid_later", 64'(bif.out_valid), 64'd0);

    // 256 jobs: counter wraps back to 0
    for (int j = 0; j < 256; j++) begin
      run_job(16'(j), 16'(j + 1), 16'(j * 3), 16'(j ^ 16'h00F0), 1 + (j % 3), "wrap");
    end
    chk("wrap_job_cnt_zero", 64'(bif.job_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
